// File: rtl/lfsr_hexdisp.sv
// lfsr_hexdisp: Fibonacci-style LFSR with free-run, single-step and load
// control. It includes lock-up recovery, a seven-segment hex decode of the
// state and an optional cycle-length (period) measurement.
//
// Parameters
//   WIDTH    : LFSR state width, a multiple of 4 in 4..32.
//   TAPS     : feedback mask; bit i set puts state[i] into the XOR feedback.
//   SEED     : nonzero state used at reset and for lock-up recovery.
//   PRESCALE : idle cycles between free-running advances (0 = every cycle).
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset.
//   run          : free-running enable; step is ignored while it is high.
//   step         : single advance request when run is low.
//   load         : synchronous load of load_val; has priority over advancing.
//   load_val     : value written on load.
//   state        : current LFSR register.
//   tick         : one-cycle pulse on the first cycle of each new state.
//   lockup       : state is all-zero (combinational).
//   seg          : active-low hex glyph per nibble, {a,b,c,d,e,f,g,dp}.
//   period       : measured cycle length (advances back to the reference).
//   period_valid : period holds a measurement.
//
// Build option
//   LFSR_PERIOD_CNT_EN : when defined, the period counter is built; when it
//   is not defined, period and period_valid are tied low.

`default_nettype none

module lfsr_hexdisp #(
  parameter int unsigned           WIDTH    = 8,
  parameter logic [WIDTH-1:0]      TAPS     = 'h1D,
  parameter logic [WIDTH-1:0]      SEED     = 'h1,
  parameter int unsigned           PRESCALE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     state,
  output logic                 tick,
  output logic                 lockup,
  output logic [2*WIDTH-1:0]   seg,
  output logic [WIDTH:0]       period,
  output logic                 period_valid
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned PW   = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE);

  logic [WIDTH-1:0] state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;

  logic             adv;        // an advance happens this cycle
  logic             recover;    // current state is the all-zero lock-up state
  logic             fb;
  logic [WIDTH-1:0] shift_val;  // state after a normal shift

  // Next-state: load beats advance beats hold.
  always_comb begin
    adv       = 1'b0;
    presc_d   = '0;
    state_d   = state_q;
    tick_d    = 1'b0;
    fb        = ^(state_q & TAPS);
    shift_val = {fb, state_q[WIDTH-1:1]};
    recover   = (state_q == '0);

    if (load) begin
      state_d = load_val;
      tick_d  = 1'b1;
    end else begin
      if (run) begin
        // Advance when the prescaler reaches PRESCALE, then wrap it.
        if (presc_q == PRESC_MAX) begin
          adv = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else begin
        adv = step;
      end

      if (adv) begin
        state_d = recover ? SEED : shift_val;
        tick_d  = 1'b1;
      end
    end
  end

  // Core registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign state  = state_q;
  assign tick   = tick_q;
  assign lockup = (state_q == '0);

  // Active-low hex glyph, bit7=a .. bit1=g, bit0=dp (always off).
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    g = 8'hFF;
    case (n)
      4'h0: g = 8'b0000_0011;
      4'h1: g = 8'b1001_1111;
      4'h2: g = 8'b0010_0101;
      4'h3: g = 8'b0000_1101;
      4'h4: g = 8'b1001_1001;
      4'h5: g = 8'b0100_1001;
      4'h6: g = 8'b0100_0001;
      4'h7: g = 8'b0001_1111;
      4'h8: g = 8'b0000_0001;
      4'h9: g = 8'b0000_1001;
      4'hA: g = 8'b0001_0001;
      4'hB: g = 8'b1100_0001;
      4'hC: g = 8'b0110_0011;
      4'hD: g = 8'b1000_0101;
      4'hE: g = 8'b0110_0001;
      4'hF: g = 8'b0111_0001;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // One glyph per state nibble.
  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    assign seg[8*i +: 8] = hex_glyph(state_q[4*i +: 4]);
  end

`ifdef LFSR_PERIOD_CNT_EN

  localparam logic [WIDTH:0] CNT_MAX = '1;

  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             pv_q, pv_d;

  // Period measurement: count advances since the last reference event and
  // latch the length when the state returns to the reference value.
  always_comb begin
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    period_d = period_q;
    pv_d     = pv_q;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (WIDTH+1)'(1);

    if (load) begin
      ref_d = load_val;
      cnt_d = '0;
      pv_d  = 1'b0;
    end else if (adv) begin
      if (recover) begin
        // Lock-up recovery restarts the measurement from SEED.
        ref_d = SEED;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
        if (shift_val == ref_q) begin
          period_d = cnt_inc;
          pv_d     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ref_q    <= SEED;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;

`else

  assign period       = '0;
  assign period_valid = 1'b0;

`endif

endmodule

`default_nettype wire

// File: doc/lfsr_hexdisp.md
LFSR_HEXDISP -- requirements
Module: lfsr_hexdisp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the LFSR state width; legal values are multiples of 4 from 4 to 32.
REQ-002 SHALL have parameter TAPS, default 8'h1D (WIDTH bits), a feedback tap mask in which bit i=1 includes state[i] in the feedback.
REQ-003 SHALL have parameter SEED, default 1 (WIDTH bits, nonzero), the state value taken at reset.
REQ-004 SHALL have parameter PRESCALE, default 0, giving the number of idle cycles between automatic advances (0 = advance every cycle).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port run, input, 1 bit: free-running mode enable.
REQ-008 SHALL have port step, input, 1 bit: single-step request, sampled each cycle.
REQ-009 SHALL have port load, input, 1 bit: synchronous state load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-011 SHALL have port state, output, WIDTH bits: current LFSR register.
REQ-012 SHALL have port tick, output, 1 bit: pulse marking a state change.
REQ-013 SHALL have port lockup, output, 1 bit: state is all-zero.
REQ-014 SHALL have port seg, output, 2*WIDTH bits: seven-segment codes, 8 bits per hex digit.
REQ-015 SHALL have port period, output, WIDTH+1 bits: measured cycle length.
REQ-016 SHALL have port period_valid, output, 1 bit: period holds a measurement.

Function
REQ-017 SHALL, on an advance, set state <= {fb, state[WIDTH-1:1]} with fb = XOR-reduce(state & TAPS).
REQ-018 SHALL apply per-cycle priority: load first, then advance, then hold.
REQ-019 SHALL, when load=1, set state <= load_val and clear the prescaler, independent of run and step.
REQ-020 SHALL, with run=1, advance when the prescaler equals PRESCALE, then wrap the prescaler to 0; otherwise the prescaler increments.
REQ-021 SHALL, with run=0, hold the prescaler at 0 and advance exactly once for each cycle in which step=1.
REQ-022 SHALL ignore step while run=1.
REQ-023 SHALL, when an advance occurs with state all-zero, load SEED instead of applying the shift (lock-up recovery).
REQ-024 SHALL drive lockup combinationally as (state == 0).
REQ-025 SHALL register tick so that it is high for exactly one cycle, coincident with the first cycle of each new state produced by an advance or a load.
REQ-026 SHALL drive seg[8i+7:8i] combinationally from nibble state[4i+3:4i] as an active-low hex glyph.
REQ-027 SHALL map each glyph as bit7=a .. bit1=g, bit0=dp, with dp held at 1 (off).
REQ-028 SHALL use these example glyph codes: 0=0000_0011, 1=1001_1111, 8=0000_0001, F=0111_0001.

Reset
REQ-029 SHALL, while rst=1, asynchronously force state=SEED, prescaler=0, tick=0, period=0, period_valid=0, and the internal step counter to 0.
REQ-030 SHALL resume on the first clk edge after rst deasserts, whether or not a run or step operation was in progress.

Configuration
REQ-031 SHALL, with macro LFSR_PERIOD_CNT_EN defined, count advances since the last reference event in a WIDTH+1-bit counter that saturates at all-ones.
REQ-032 SHALL treat reset, load, and lock-up recovery as reference events; each one captures the new state as the reference value and zeroes the counter.
REQ-033 SHALL, when an advance makes state equal the reference value, latch period = count + 1 and set period_valid=1.
REQ-034 SHALL clear period_valid only on reset or load.
REQ-035 SHALL, without LFSR_PERIOD_CNT_EN, tie period and period_valid to 0, keep the ports present, and include no counter logic.

Verification
REQ-036 SHALL cover: defaults, release rst, run=1 -> state 01,80,40,20,10,88 on consecutive cycles with tick high each cycle.
REQ-037 SHALL cover: defaults, state=80 -> seg[15:8]=0000_0001 and seg[7:0]=0000_0011.
REQ-038 SHALL cover: PRESCALE=3, run=1 -> one advance every 4 cycles; run=0 with step pulsed twice -> exactly two advances.
REQ-039 SHALL cover: load=1 with load_val=0 -> lockup=1; next step -> state=SEED and lockup=0.
REQ-040 SHALL cover: load and step in the same cycle -> state=load_val and no advance.
REQ-041 SHALL cover: WIDTH=4, TAPS=4'b0011, LFSR_PERIOD_CNT_EN defined, run=1 -> period=15 and period_valid=1 after 15 advances; assert rst mid-run -> state=1 and period_valid=0 immediately, without waiting for a clock edge.
